// File: rtl/des_pkg.sv
// DES tables (FIPS 46-3 bit numbering, 1 = MSB), permutation/S-box helpers and key schedule.
package des_pkg;

  typedef int unsigned ptab_t [64];
  typedef logic [1:16][1:48] subkeys_t;

  localparam ptab_t IP_T = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam ptab_t FP_T = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  // Tables shorter than 64 entries are zero-padded; permute() never reads the padding.
  localparam ptab_t E_T = '{
    32,  1,  2,  3,  4,  5,  4,  5,
     6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27,
    28, 29, 28, 29, 30, 31, 32,  1,
     0,  0,  0,  0,  0,  0,  0,  0,
     0,  0,  0,  0,  0,  0,  0,  0
  };

  localparam ptab_t P_T = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25,
     0,  0,  0,  0,  0,  0,  0,  0,
     0,  0,  0,  0,  0,  0,  0,  0,
     0,  0,  0,  0,  0,  0,  0,  0,
     0,  0,  0,  0,  0,  0,  0,  0
  };

  localparam ptab_t PC1_T = '{
    57, 49, 41, 33, 25, 17,  9,  1,
    58, 50, 42, 34, 26, 18, 10,  2,
    59, 51, 43, 35, 27, 19, 11,  3,
    60, 52, 44, 36, 63, 55, 47, 39,
    31, 23, 15,  7, 62, 54, 46, 38,
    30, 22, 14,  6, 61, 53, 45, 37,
    29, 21, 13,  5, 28, 20, 12,  4,
     0,  0,  0,  0,  0,  0,  0,  0
  };

  localparam ptab_t PC2_T = '{
    14, 17, 11, 24,  1,  5,  3, 28,
    15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56,
    34, 53, 46, 42, 50, 36, 29, 32,
     0,  0,  0,  0,  0,  0,  0,  0,
     0,  0,  0,  0,  0,  0,  0,  0
  };

  localparam int unsigned SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int unsigned SBOX [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  // Input and output are left-aligned: table entry j selects din bit j, first n outputs valid.
  function automatic logic [1:64] permute(input logic [1:64] din, input ptab_t tbl,
                                          input int unsigned n);
    logic [1:64] res;
    logic [6:0]  idx;
    logic        b;
    res = '0;
    idx = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      b = 1'b0;
      if (i < n) begin
        idx = 7'(tbl[i]);
        b   = din[idx];
      end
      res = {res[2:64], b};
    end
    return res;
  endfunction

  function automatic logic [1:4] sbox(input logic [2:0] box, input logic [1:6] b);
    logic [5:0] idx;
    idx = {b[1], b[6], b[2:5]};
    return 4'(SBOX[box][idx]);
  endfunction

  function automatic subkeys_t key_schedule(input logic [1:64] key);
    subkeys_t    ks;
    logic [1:56] cd;
    logic [1:28] c, d;
    logic [1:48] kn;
    ks = '0;
    cd = 56'(permute(key, PC1_T, 56) >> 8);
    c  = cd[1:28];
    d  = cd[29:56];
    for (int unsigned i = 0; i < 16; i++) begin
      if (SHIFTS[i] == 1) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end else begin
        c = {c[3:28], c[1:2]};
        d = {d[3:28], d[1:2]};
      end
      kn = 48'(permute({c, d, 8'h00}, PC2_T, 48) >> 16);
      ks = {ks[2:16], kn};
    end
    return ks;
  endfunction

endpackage

// File: rtl/des_round.sv
// One DES Feistel round: L' = R, R' = L ^ f(R, K), with f = P(S(E(R) ^ K)).
module des_round
  import des_pkg::*;
(
  input  logic [1:32] l,
  input  logic [1:32] r,
  input  logic [1:48] subkey,
  output logic [1:32] l_next,
  output logic [1:32] r_next
);

  logic [1:48] x;
  logic [1:32] s;

  assign x = 48'(permute({r, 32'h0}, E_T, 48) >> 16) ^ subkey;

  for (genvar b = 0; b < 8; b++) begin : g_sbox
    assign s[4*b+1 +: 4] = sbox(3'(b), x[6*b+1 +: 6]);
  end

  assign l_next = r;
  assign r_next = l ^ 32'(permute({s, 32'h0}, P_T, 32) >> 32);

endmodule

// File: rtl/des.sv
// Fully unrolled single-block DES encryptor; optional round-trip decryptor built when
// DES_DECRYPT_EN is defined (otherwise Decrypt is tied to zero).
module des
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:64] key,
  input  logic [1:64] msg,
  output logic [1:64] Encrypt,
  output logic [1:64] Decrypt
);

  subkeys_t    ks_enc;
  logic [1:64] ip_enc;
  logic [1:64] ct;
  logic [1:32] l_enc [17];
  logic [1:32] r_enc [17];

  assign ks_enc   = key_schedule(key);
  assign ip_enc   = permute(msg, IP_T, 64);
  assign l_enc[0] = ip_enc[1:32];
  assign r_enc[0] = ip_enc[33:64];

  for (genvar i = 0; i < 16; i++) begin : g_enc
    des_round u_round (
      .l      (l_enc[i]),
      .r      (r_enc[i]),
      .subkey (ks_enc[i+1]),
      .l_next (l_enc[i+1]),
      .r_next (r_enc[i+1])
    );
  end

  assign ct = permute({r_enc[16], l_enc[16]}, FP_T, 64);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Encrypt <= '0;
    else        Encrypt <= ct;
  end

`ifdef DES_DECRYPT_EN
  subkeys_t    ks_dec;
  logic [1:64] key_d;
  logic [1:64] ip_dec;
  logic [1:64] pt;
  logic [1:32] l_dec [17];
  logic [1:32] r_dec [17];
  logic        primed;

  assign ks_dec   = key_schedule(key_d);
  assign ip_dec   = permute(Encrypt, IP_T, 64);
  assign l_dec[0] = ip_dec[1:32];
  assign r_dec[0] = ip_dec[33:64];

  for (genvar i = 0; i < 16; i++) begin : g_dec
    des_round u_round (
      .l      (l_dec[i]),
      .r      (r_dec[i]),
      .subkey (ks_dec[16-i]),
      .l_next (l_dec[i+1]),
      .r_next (r_dec[i+1])
    );
  end

  assign pt = permute({r_dec[16], l_dec[16]}, FP_T, 64);

  // Encrypt is only a real block one edge after reset; until then dec(0, 0) is nonzero,
  // so primed holds Decrypt at zero for that first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_d   <= '0;
      primed  <= 1'b0;
      Decrypt <= '0;
    end else begin
      key_d   <= key;
      primed  <= 1'b1;
      Decrypt <= primed ? pt : '0;
    end
  end
`else
  assign Decrypt = '0;
`endif

endmodule

// File: tb/tb_des.sv
// Scoreboard bench for des: known-answer vectors, back-to-back key changes, mid-stream reset.
module tb_des;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:64] key   = '0;
  logic [1:64] msg   = '0;
  logic [1:64] Encrypt;
  logic [1:64] Decrypt;

  des dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key     (key),
    .msg     (msg),
    .Encrypt (Encrypt),
    .Decrypt (Decrypt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [63:0] val;
    int          id;
  } exp_t;

  exp_t        enc_q[$];
  exp_t        dec_q[$];
  int unsigned edge_cnt = 0;
  int unsigned n_pass   = 0;
  int unsigned n_total  = 0;

  localparam int NV = 6;
  localparam int ID_RST = 90;
  localparam int ID_PRIME = 91;
  logic [63:0] vk [NV];
  logic [63:0] vm [NV];
  logic [63:0] vc [NV];

  function automatic void check(string tag, int id, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s id=%0d edge=%0d: got %h expected %h", tag, id, edge_cnt, got, exp);
  endfunction

  function automatic logic [63:0] dec_exp(logic [63:0] m);
`ifdef DES_DECRYPT_EN
    return m;
`else
    return '0 & m;
`endif
  endfunction

  function automatic void push_enc(int unsigned due, logic [63:0] v, int id);
    exp_t e;
    e.due = due; e.val = v; e.id = id;
    enc_q.push_back(e);
  endfunction

  function automatic void push_dec(int unsigned due, logic [63:0] v, int id);
    exp_t e;
    e.due = due; e.val = v; e.id = id;
    dec_q.push_back(e);
  endfunction

  // Monitor: sample #1 after each rising edge and retire every expectation due now.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      while (enc_q.size() != 0 && enc_q[0].due <= edge_cnt) begin
        exp_t e;
        e = enc_q.pop_front();
        check("Encrypt", e.id, Encrypt, e.val);
      end
      while (dec_q.size() != 0 && dec_q[0].due <= edge_cnt) begin
        exp_t e;
        e = dec_q.pop_front();
        check("Decrypt", e.id, Decrypt, e.val);
      end
    end
  end

  // Drive one vector at the falling edge; fresh also releases reset on that edge.
  task automatic apply(int v, bit fresh);
    @(negedge clk);
    if (fresh) rst_n = 1'b1;
    key = vk[v];
    msg = vm[v];
    push_enc(edge_cnt + 1, vc[v], v);
    if (fresh) push_dec(edge_cnt + 1, '0, ID_PRIME);
    push_dec(edge_cnt + 2, dec_exp(vm[v]), v);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    while (enc_q.size() != 0 && enc_q[$].due > edge_cnt) void'(enc_q.pop_back());
    while (dec_q.size() != 0 && dec_q[$].due > edge_cnt) void'(dec_q.pop_back());
    #1;
    check("Encrypt_async_rst", ID_RST, Encrypt, '0);
    check("Decrypt_async_rst", ID_RST, Decrypt, '0);
    push_enc(edge_cnt + 1, '0, ID_RST);
    push_dec(edge_cnt + 1, '0, ID_RST);
  endtask

  int order [8] = '{4, 1, 3, 0, 5, 2, 1, 0};

  initial begin
    vk[0] = 64'h133457799BBCDFF1; vm[0] = 64'h0123456789ABCDEF; vc[0] = 64'h85E813540F0AB405;
    vk[1] = 64'h0E329232EA6D0D73; vm[1] = 64'h8787878787878787; vc[1] = 64'h0000000000000000;
    vk[2] = 64'h0000000000000000; vm[2] = 64'h0000000000000000; vc[2] = 64'h8CA64DE9C1B123A7;
    vk[3] = 64'h133457799BBCDFF1 ^ 64'h0101010101010101;
    vm[3] = 64'h0123456789ABCDEF; vc[3] = 64'h85E813540F0AB405;
    vk[4] = 64'h0101010101010101; vm[4] = 64'h95F8A5E5DD31D900; vc[4] = 64'h8000000000000000;
    vk[5] = 64'h0000000000000000; vm[5] = 64'h8CA64DE9C1B123A7; vc[5] = 64'h0000000000000000;

    key = vk[0];
    msg = vm[0];
    #1 rst_n = 1'b0;
    #1;
    check("Encrypt_rst", ID_RST, Encrypt, '0);
    check("Decrypt_rst", ID_RST, Decrypt, '0);
    push_enc(1, '0, ID_RST);
    push_dec(1, '0, ID_RST);

    apply(0, 1'b1);
    for (int v = 1; v < NV; v++) apply(v, 1'b0);
    for (int i = 0; i < 8; i++) apply(order[i], 1'b0);

    pulse_reset();
    apply(2, 1'b1);
    apply(1, 1'b0);
    apply(0, 1'b0);
    apply(3, 1'b0);

    for (int i = 0; i < 8 && (enc_q.size() != 0 || dec_q.size() != 0); i++) @(negedge clk);
    while (enc_q.size() != 0) begin
      exp_t e;
      e = enc_q.pop_front();
      n_total++;
      $display("FAIL Encrypt_timeout id=%0d: got no sample, expected %h by edge %0d", e.id, e.val, e.due);
    end
    while (dec_q.size() != 0) begin
      exp_t e;
      e = dec_q.pop_front();
      n_total++;
      $display("FAIL Decrypt_timeout id=%0d: got no sample, expected %h by edge %0d", e.id, e.val, e.due);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
